// File: rtl/dii_package.sv
// Debug interconnect flit type shared by all DII stream producers and consumers.
package dii_package;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

endpackage

// File: rtl/osd_dii_out_arbiter_pkg.sv
// Shared constants, state encoding and grant encoding for the DII output arbiter.
package osd_dii_arb_package;

  localparam int MAX_EVT = 8;
  localparam logic [3:0] ARB_SRC_REG = 4'd0;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  // Event source k is reported on grant_src as k+1; 0 is the register-access stream.
  function automatic logic [3:0] evt_grant(input int k);
    return 4'(k + 1);
  endfunction

endpackage

// File: rtl/osd_dii_out_arbiter_picker.sv
// Combinational rotating-priority one-hot picker: req[ptr] is highest priority,
// then increasing indices with wrap-around. ptr must be below WIDTH.
module osd_rr_picker #(
  parameter int WIDTH = 2,
  parameter int PTR_W = 1
) (
  input  logic [WIDTH-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [WIDTH-1:0] gnt
);

  logic [WIDTH-1:0] rot_req;
  logic [WIDTH-1:0] rot_gnt;

  // Rotate so the pointer slot sits at bit 0, isolate the lowest set bit, rotate back.
  assign rot_req = WIDTH'({req, req} >> ptr);
  assign rot_gnt = rot_req & (~rot_req + WIDTH'(1));
  assign gnt     = WIDTH'(({rot_gnt, rot_gnt} << ptr) >> WIDTH);

endmodule

// File: rtl/osd_dii_out_arbiter.sv
// Packet-granular arbiter sharing one DII output between register responses and
// NUM_EVT event sources. Define OSD_DII_ARB_FAIR_REG_EN to put reg_in in the rotation.
module osd_dii_out_arbiter
  import dii_package::*;
  import osd_dii_arb_package::*;
#(
  parameter int NUM_EVT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  dii_flit                 reg_in,
  output logic                    reg_in_ready,
  input  dii_flit [NUM_EVT-1:0]   evt_in,
  output logic    [NUM_EVT-1:0]   evt_in_ready,
  output dii_flit                 debug_out,
  input  logic                    debug_out_ready,
  output logic    [3:0]           grant_src,
  output logic                    locked
);

`ifdef OSD_DII_ARB_FAIR_REG_EN
  localparam int SLOTS = NUM_EVT + 1;
`else
  localparam int SLOTS = NUM_EVT;
`endif
  localparam int PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  arb_state_t       state_q, state_d;
  logic [3:0]       lock_src_q, lock_src_d;
  logic [3:0]       grant_q, grant_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             gap_q, gap_d;

  logic [NUM_EVT-1:0] evt_vld;
  logic [SLOTS-1:0]   slot_req;
  logic [SLOTS-1:0]   slot_gnt;
  logic [3:0]         win_src;
  logic [3:0]         sel_src;
  dii_flit            sel_flit;
  logic               any_req;
  logic               own_act;
  logic               out_vld;
  logic               xfer;

  for (genvar k = 0; k < NUM_EVT; k++) begin : g_vld
    assign evt_vld[k] = evt_in[k].valid;
  end

`ifdef OSD_DII_ARB_FAIR_REG_EN
  assign slot_req = {reg_in.valid, evt_vld};
`else
  assign slot_req = evt_vld;
`endif
  assign any_req = reg_in.valid | (|evt_vld);

  osd_rr_picker #(
    .WIDTH (SLOTS),
    .PTR_W (PTR_W)
  ) u_picker (
    .req (slot_req),
    .ptr (rr_ptr_q),
    .gnt (slot_gnt)
  );

  // The reg slot (fair build) and strict reg priority (default build) both map to ARB_SRC_REG.
  always_comb begin
    win_src = ARB_SRC_REG;
    for (int k = 0; k < NUM_EVT; k++) begin
      if (slot_gnt[k]) win_src = evt_grant(k);
    end
`ifndef OSD_DII_ARB_FAIR_REG_EN
    if (reg_in.valid) win_src = ARB_SRC_REG;
`endif
  end

  assign sel_src = (state_q == ARB_LOCKED) ? lock_src_q : win_src;

  always_comb begin
    sel_flit = reg_in;
    for (int k = 0; k < NUM_EVT; k++) begin
      if (sel_src == evt_grant(k)) sel_flit = evt_in[k];
    end
  end

  // A packet finishing in LOCKED leaves one idle cycle (gap_q) before the next arbitration.
  assign own_act = ~rst & ((state_q == ARB_LOCKED) | (any_req & ~gap_q));
  assign out_vld = own_act & sel_flit.valid;
  assign xfer    = out_vld & debug_out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      lock_src_q <= ARB_SRC_REG;
      grant_q    <= ARB_SRC_REG;
      rr_ptr_q   <= '0;
      gap_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_src_q <= lock_src_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      gap_q      <= gap_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    lock_src_d = lock_src_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    gap_d      = 1'b0;
    if (xfer) begin
      grant_d = sel_src;
      if (sel_flit.last) begin
        state_d = ARB_IDLE;
        gap_d   = (state_q == ARB_LOCKED);
`ifdef OSD_DII_ARB_FAIR_REG_EN
        rr_ptr_d = (sel_src == ARB_SRC_REG) ? '0 : PTR_W'(sel_src);
`else
        if (sel_src != ARB_SRC_REG) rr_ptr_d = PTR_W'(int'(sel_src) % NUM_EVT);
`endif
      end else begin
        state_d    = ARB_LOCKED;
        lock_src_d = sel_src;
      end
    end
  end

  // Output logic
  always_comb begin
    debug_out    = out_vld ? sel_flit : '0;
    reg_in_ready = own_act & debug_out_ready & (sel_src == ARB_SRC_REG);
    evt_in_ready = '0;
    for (int k = 0; k < NUM_EVT; k++) begin
      evt_in_ready[k] = own_act & debug_out_ready & (sel_src == evt_grant(k));
    end
    grant_src = rst ? ARB_SRC_REG : (own_act ? sel_src : grant_q);
    locked    = (state_q == ARB_LOCKED);
  end

endmodule

// File: tb/tb_osd_dii_out_arbiter.sv
// Randomized and directed bench for osd_dii_out_arbiter against a packet-level reference model.
module tb_osd_dii_out_arbiter;
  import dii_package::*;

  localparam int N = 3;

  logic            clk = 1'b0;
  logic            rst;
  dii_flit         reg_in;
  logic            reg_in_ready;
  dii_flit [N-1:0] evt_in;
  logic [N-1:0]    evt_in_ready;
  dii_flit         debug_out;
  logic            debug_out_ready;
  logic [3:0]      grant_src;
  logic            locked;

  always #5 clk = ~clk;

  osd_dii_out_arbiter #(.NUM_EVT(N)) dut (
    .clk             (clk),
    .rst             (rst),
    .reg_in          (reg_in),
    .reg_in_ready    (reg_in_ready),
    .evt_in          (evt_in),
    .evt_in_ready    (evt_in_ready),
    .debug_out       (debug_out),
    .debug_out_ready (debug_out_ready),
    .grant_src       (grant_src),
    .locked          (locked)
  );

  int errors = 0;
  int checks = 0;

  // Source s: 0 = reg_in, e+1 = evt_in[e]. Queue entries: bit16 = last, [15:0] = data.
  int unsigned q [N+1][$];
  int          vprob [N+1];
  int          rprob;
  bit          cur_v [N+1];
  int unsigned order [$];

  // Reference model: current owner (-1 = none), rotation pointer, last grant, post-packet gap.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_grant = 0;
  bit m_gap   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick();
`ifdef OSD_DII_ARB_FAIR_REG_EN
    for (int i = 0; i <= N; i++) begin
      int slot = (m_ptr + i) % (N + 1);
      int src  = (slot == N) ? 0 : slot + 1;
      if (cur_v[src]) return src;
    end
`else
    if (cur_v[0]) return 0;
    for (int i = 0; i < N; i++) begin
      int e = (m_ptr + i) % N;
      if (cur_v[e+1]) return e + 1;
    end
`endif
    return -1;
  endfunction

  function automatic int next_ptr(input int src);
`ifdef OSD_DII_ARB_FAIR_REG_EN
    return src;
`else
    return (src == 0) ? m_ptr : src % N;
`endif
  endfunction

  task automatic add_pkt(input int s, input int len);
    for (int i = 0; i < len; i++) begin
      int unsigned w = $urandom_range(16'hffff);
      if (i == len - 1) w = w | 32'h1_0000;
      q[s].push_back(w);
    end
  endtask

  task automatic drive();
    for (int s = 0; s <= N; s++) begin
      logic [17:0] f;
      int unsigned h;
      cur_v[s] = (q[s].size() > 0) && ($urandom_range(99) < vprob[s]);
      if (cur_v[s]) begin
        h = q[s][0];
        f = {1'b1, h[16], h[15:0]};
      end else begin
        f = {1'b0, 17'($urandom)};
      end
      if (s == 0) reg_in = f;
      else        evt_in[s-1] = f;
    end
    debug_out_ready = ($urandom_range(99) < rprob);
  endtask

  task automatic cycle();
    int          sel;
    bit          ev;
    bit          xf;
    int unsigned h;
    logic [17:0] ef;
    logic [N:0]  er;
    logic [3:0]  eg;
    logic [3:0]  obs_g;
    @(negedge clk);
    sel = -1;
    if (!rst) begin
      if (m_owner >= 0) sel = m_owner;
      else if (!m_gap)  sel = pick();
    end
    ev = (sel >= 0) && cur_v[sel];
    h  = (sel >= 0 && q[sel].size() > 0) ? q[sel][0] : 0;
    ef = ev ? {1'b1, h[16], h[15:0]} : 18'h0;
    er = (sel >= 0) ? ((N+1)'(debug_out_ready) << sel) : '0;
    eg = rst ? 4'd0 : ((sel >= 0) ? 4'(sel) : 4'(m_grant));
    check_eq("debug_out", 32'(debug_out), 32'(ef));
    check_eq("ready", 32'({evt_in_ready, reg_in_ready}), 32'(er));
    check_eq("grant_src", 32'(grant_src), 32'(eg));
    check_eq("locked", 32'(locked), 32'(m_owner >= 0));
    obs_g = grant_src;
    xf = ev && debug_out_ready;
    @(posedge clk);
    #1;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_grant = 0; m_gap = 0;
    end else begin
      m_gap = 0;
      if (xf) begin
        if (m_owner < 0) order.push_back(32'(obs_g));
        void'(q[sel].pop_front());
        m_grant = sel;
        if (h[16]) begin
          m_gap   = (m_owner >= 0);
          m_owner = -1;
          m_ptr   = next_ptr(sel);
        end else begin
          m_owner = sel;
        end
      end
    end
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int s = 0; s <= N; s++) begin
      q[s].delete();
      vprob[s] = 0;
    end
    rprob = 100;
    drive();
    cycle();
    cycle();
    rst = 1'b0;
    order.delete();
  endtask

  task automatic run_until_order(input string tag, input int cnt);
    int n = 0;
    while (order.size() < cnt && n < 200) begin
      cycle();
      n++;
    end
    check_eq(tag, 32'(n < 200), 32'd1);
  endtask

  initial begin
    int n;
    int exp_rr [6] = '{1, 2, 3, 1, 2, 3};
`ifdef OSD_DII_ARB_FAIR_REG_EN
    int exp_fair [6] = '{1, 2, 0, 1, 2, 0};
`else
    int exp_fair [6] = '{0, 0, 0, 0, 0, 0};
`endif
    rst = 1'b1;
    reg_in = '0;
    evt_in = '0;
    debug_out_ready = 1'b0;
    do_reset();

    // Register-only packet
    for (int i = 1; i <= 4; i++) q[0].push_back(32'h1000 + i + ((i == 4) ? 32'h1_0000 : 0));
    vprob[0] = 100;
    drive();
    repeat (4) cycle();
    check_eq("reg_drain", 32'(q[0].size()), 32'd0);
    check_eq("reg_pkts", 32'(order.size()), 32'd1);
    repeat (2) cycle();

    // Non-interleave: reg request arrives in the middle of an event packet
    do_reset();
    vprob[0] = 100; vprob[1] = 100;
    add_pkt(1, 5);
    drive();
    n = 0;
    while (q[1].size() > 3 && n < 50) begin cycle(); n++; end
    add_pkt(0, 2);
    n = 0;
    while (q[0].size() > 0 && n < 50) begin cycle(); n++; end
    check_eq("nonint_timeout", 32'(n < 50), 32'd1);
    check_eq("nonint_cnt", 32'(order.size()), 32'd2);
    if (order.size() == 2) begin
      check_eq("nonint_first", order[0], 32'd1);
      check_eq("nonint_second", order[1], 32'd0);
    end

    // Round robin among three continuously requesting event sources
    do_reset();
    for (int s = 1; s <= N; s++) begin
      vprob[s] = 100;
      for (int p = 0; p < 3; p++) add_pkt(s, 2);
    end
    drive();
    run_until_order("rr_timeout", 6);
    for (int i = 0; i < 6 && i < order.size(); i++) check_eq($sformatf("rr_order%0d", i), order[i], 32'(exp_rr[i]));

    // Fairness of reg_in against two event sources
    do_reset();
    for (int s = 0; s < 3; s++) begin
      vprob[s] = 100;
      for (int p = 0; p < 6; p++) add_pkt(s, 2);
    end
    drive();
    run_until_order("fair_timeout", 6);
    for (int i = 0; i < 6 && i < order.size(); i++) check_eq($sformatf("fair_order%0d", i), order[i], 32'(exp_fair[i]));

    // Reset in the middle of a 6-flit packet
    do_reset();
    vprob[1] = 100;
    add_pkt(1, 6);
    drive();
    n = 0;
    while (q[1].size() > 3 && n < 50) begin cycle(); n++; end
    check_eq("rstmid_timeout", 32'(n < 50), 32'd1);
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    q[1].delete();
    order.delete();
    vprob[2] = 100; vprob[3] = 100;
    add_pkt(2, 2);
    add_pkt(3, 2);
    drive();
    run_until_order("rstmid_fresh_timeout", 1);
    if (order.size() > 0) check_eq("rstmid_fresh", order[0], 32'd2);

    // Randomized traffic with backpressure and valid gaps
    do_reset();
    for (int s = 0; s <= N; s++) vprob[s] = 60;
    rprob = 60;
    drive();
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s <= N; s++)
        if (q[s].size() == 0 && $urandom_range(99) < 30) add_pkt(s, $urandom_range(1, 5));
      if (c % 500 == 250) rprob = 100 - rprob / 2;
      cycle();
    end
    check_eq("rand_progress", 32'(order.size() > 50), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
